mem_result_drain: RTL and testbench
===================================

Name: mem_result_drain

Overview:
- Downstream stage of the two-memory add/sub transfer datapath.
- On a Start pulse, reads NUM_WORDS results out of result memory B over its combinational read port.
- Presents the results as a valid/ready byte stream, then appends one checksum beat flagged Last.
- Lets a consumer (bus interface, test harness) unload memory B without knowing its addressing.

Parameters:
DATA_WIDTH, 8, width of result words and stream data.
ADDR_WIDTH, 2, memory B address width.
NUM_WORDS, 4, words drained per run; legal range 1..2**ADDR_WIDTH.

Ports:
Clk  input  1  single clock, all state updates on rising edge.
Reset  input  1  asynchronous, active-low reset (0 = reset).
Start  input  1  one-cycle request to begin a drain; honoured only in IDLE.
RdAddr  output  ADDR_WIDTH  read address to memory B.
RdData  input  DATA_WIDTH  memory B read data; combinational, valid in the same cycle as RdAddr.
DataOut  output  DATA_WIDTH  stream data, registered.
Valid  output  1  stream data valid.
Ready  input  1  consumer accepts the beat when Valid && Ready at a rising edge.
Last  output  1  high with Valid on the checksum beat only.
Busy  output  1  high in every state except IDLE.
Done  output  1  one-cycle pulse after the checksum beat is accepted.

Behaviour:
- Reset asserted (Reset=0), regardless of state:
  - state=IDLE; RdAddr=0; DataOut=0; Valid=0; Last=0; Busy=0; Done=0.
  - Index counter=0; sum accumulator=0.
- Reset mid-run aborts the run with no checksum and no Done; the next run needs a fresh Start.
- State machine IDLE -> LOAD -> SEND -> (LOAD ... ) -> CSUM -> DONE -> IDLE:
  - IDLE: Start=1 -> LOAD; RdAddr=0, index=0, sum=0.
  - LOAD, one cycle: DataOut<=RdData; sum<=sum+RdData (mod 2**DATA_WIDTH) -> SEND.
  - SEND, Valid=1, Last=0, waits on Ready.
    - Ready=1 and index<NUM_WORDS-1 -> index+1, RdAddr+1, back to LOAD.
    - Ready=1 and index=NUM_WORDS-1 -> DataOut<=(0-sum) mod 2**DATA_WIDTH -> CSUM.
  - CSUM: Valid=1, Last=1; Ready=1 -> DONE.
  - DONE: Done=1 for exactly one cycle, Valid=0 -> IDLE.
- Latency and throughput:
  - Start to first Valid = 2 cycles.
  - Each data beat occupies at least 2 cycles (LOAD+SEND).
  - Minimum run = 2*NUM_WORDS+2 cycles from Start to Done.
- Handshake rules:
  - While Valid=1 && Ready=0, DataOut, Last and RdAddr hold stable.
  - Valid never drops without acceptance.
  - Ready is ignored outside SEND and CSUM.
- Start while Busy=1 is ignored and has no effect on the current run.
- Start in the same cycle as the DONE state is ignored; a Start in the following IDLE cycle is accepted.
- Checksum property: the modular sum of all data beats plus the checksum beat = 0.
- RdAddr never exceeds NUM_WORDS-1 and is not incremented past the last word (no wrap).
- NUM_WORDS=1: single LOAD/SEND, then CSUM.
- Outputs are registered or decoded from state only; no combinational path from Ready to Valid.

Test Plan:
1. Reset low for 3 cycles, release, Ready=1, no Start -> all outputs 0, RdAddr=0, Busy=0 indefinitely.
2. Memory B = {0x05,0xFA,0x03,0x07}, Ready held 1, Start pulse:
   - Beats 0x05,0xFA,0x03,0x07, then 0xF7 with Last=1.
   - Done exactly 10 cycles after Start; Busy falls with Done.
3. Same data, Ready toggled 0 for 3 cycles on each beat:
   - Identical beat sequence; DataOut and RdAddr stable while stalled.
   - No duplicated or dropped beats.
4. Start re-pulsed while streaming beat 2 -> ignored; exactly 5 beats and one Done pulse.
5. Reset driven low during the beat-1 stall:
   - Immediate IDLE, Valid=0, no Done.
   - A new Start then produces the full 5-beat sequence from address 0.
6. NUM_WORDS=1, memory B[0]=0x00 -> beats 0x00 then checksum 0x00 with Last=1; Done on the next cycle after acceptance.

Source files
------------

// File: rtl/mem_result_drain.sv
// -----------------------------------------------------------------------------
// mem_result_drain
//
// Unloads NUM_WORDS results from result memory B and presents them as a
// valid/ready byte stream, followed by one checksum beat flagged Last. The
// checksum is the two's-complement negation of the modular sum of the data
// beats, so the sum of every beat in a run (checksum included) is zero.
//
// Ports:
//   Clk      in   single clock, rising-edge
//   Reset    in   asynchronous, active-low reset
//   Start    in   one-cycle drain request, honoured only when idle
//   RdAddr   out  memory B read address
//   RdData   in   memory B read data, combinational from RdAddr
//   DataOut  out  stream data (registered)
//   Valid    out  stream data valid
//   Ready    in   consumer accepts the beat on Valid && Ready at a rising edge
//   Last     out  marks the checksum beat
//   Busy     out  high whenever a run is in progress
//   Done     out  one-cycle pulse after the checksum beat is accepted
// -----------------------------------------------------------------------------
module mem_result_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_WORDS  = 4   // legal range 1 .. 2**ADDR_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    output logic [ADDR_WIDTH-1:0] RdAddr,
    input  logic [DATA_WIDTH-1:0] RdData,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  Valid,
    input  logic                  Ready,
    output logic                  Last,
    output logic                  Busy,
    output logic                  Done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        CSUM,
        DONE
    } stateT;

    stateT                 state;
    stateT                 stateNext;
    logic [ADDR_WIDTH-1:0] wordIdx;   // doubles as the read address
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] dataReg;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and stream-control decode. Valid/Last/Busy/Done depend on
    // state only, so Ready never reaches Valid combinationally.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        stateNext = state;
        Valid     = 1'b0;
        Last      = 1'b0;
        Busy      = 1'b1;
        Done      = 1'b0;
        unique case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                stateNext = SEND;
            end
            SEND: begin
                Valid = 1'b1;
                if (Ready) begin
                    stateNext = (wordIdx == LAST_IDX) ? CSUM : LOAD;
                end
            end
            CSUM: begin
                Valid = 1'b1;
                Last  = 1'b1;
                if (Ready) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                Done      = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Datapath: word index, running sum and the output data register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wordIdx <= '0;
            sum     <= '0;
            dataReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Parked at zero so the first LOAD reads word 0.
                    wordIdx <= '0;
                    sum     <= '0;
                end
                LOAD: begin
                    dataReg <= RdData;
                    sum     <= sum + RdData;
                end
                SEND: begin
                    if (Ready) begin
                        if (wordIdx == LAST_IDX) begin
                            // sum already includes the beat being accepted.
                            dataReg <= '0 - sum;
                        end else begin
                            wordIdx <= wordIdx + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign RdAddr  = wordIdx;
    assign DataOut = dataReg;

endmodule

// File: tb/tb_mem_result_drain.sv
// -----------------------------------------------------------------------------
// tb_mem_result_drain
//
// Directed bench for mem_result_drain: a 4-word instance against memory B =
// {05, FA, 03, 07} (expected checksum F7) and a 1-word instance with B[0]=00.
// -----------------------------------------------------------------------------
module tb_mem_result_drain;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          Clk   = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0;
    logic          Ready = 1'b0;
    logic [AW-1:0] RdAddr;
    logic [DW-1:0] RdData;
    logic [DW-1:0] DataOut;
    logic          Valid;
    logic          Last;
    logic          Busy;
    logic          Done;
    logic [DW-1:0] memB [4];

    logic          start1 = 1'b0;
    logic          ready1 = 1'b0;
    logic [AW-1:0] rdAddr1;
    logic [DW-1:0] rdData1;
    logic [DW-1:0] dataOut1;
    logic          valid1;
    logic          last1;
    logic          busy1;
    logic          done1;
    logic [DW-1:0] memB1 [4];

    assign RdData  = memB[RdAddr];
    assign rdData1 = memB1[rdAddr1];

    always #5 Clk = ~Clk;

    mem_result_drain #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .RdAddr(RdAddr), .RdData(RdData),
        .DataOut(DataOut), .Valid(Valid), .Ready(Ready), .Last(Last),
        .Busy(Busy), .Done(Done)
    );

    mem_result_drain #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(start1), .RdAddr(rdAddr1), .RdData(rdData1),
        .DataOut(dataOut1), .Valid(valid1), .Ready(ready1), .Last(last1),
        .Busy(busy1), .Done(done1)
    );

    int checks = 0;
    int errors = 0;

    // Results of the last drain() call.
    logic [DW-1:0] beats[$];
    logic          lasts[$];
    int            doneCount;
    int            doneCycle;
    int            firstValidCycle;
    logic          busyAfterDone;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive Start for exactly one rising edge; drain() drops it again.
    task automatic pulseStart();
        @(negedge Clk);
        Ready = 1'b1;
        Start = 1'b1;
    endtask

    // Runs a fixed 60-cycle window after the Start edge. Each beat is stalled
    // for 'stall' cycles before being accepted; stalled outputs must hold.
    // With reStart set, Start is pulsed while beat 2 is being accepted.
    task automatic drain(input int stall, input bit reStart);
        int            stallCnt;
        bit            prevStalled;
        logic [DW-1:0] heldData;
        logic [AW-1:0] heldAddr;
        logic          heldLast;
        stallCnt        = 0;
        prevStalled     = 1'b0;
        heldData        = '0;
        heldAddr        = '0;
        heldLast        = 1'b0;
        beats.delete();
        lasts.delete();
        doneCount       = 0;
        doneCycle       = -1;
        firstValidCycle = -1;
        busyAfterDone   = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (doneCycle >= 0 && c == doneCycle + 1) busyAfterDone = Busy;
            if (Done) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = c;
            end
            if (Valid && firstValidCycle < 0) firstValidCycle = c;
            if (prevStalled) begin
                check("stall_valid", 32'(Valid), 32'(1));
                check("stall_data", 32'(DataOut), 32'(heldData));
                check("stall_addr", 32'(RdAddr), 32'(heldAddr));
                check("stall_last", 32'(Last), 32'(heldLast));
            end
            prevStalled = 1'b0;
            if (Valid) begin
                if (stallCnt < stall) begin
                    Ready       = 1'b0;
                    stallCnt++;
                    prevStalled = 1'b1;
                    heldData    = DataOut;
                    heldAddr    = RdAddr;
                    heldLast    = Last;
                end else begin
                    Ready    = 1'b1;
                    stallCnt = 0;
                    beats.push_back(DataOut);
                    lasts.push_back(Last);
                    if (reStart && beats.size() == 3) Start = 1'b1;
                end
            end else begin
                Ready = 1'b1;
            end
        end
    endtask

    // Expected stream for memory B = {05, FA, 03, 07}: 05+FA+03+07 = 09 mod 256,
    // checksum = 00 - 09 = F7.
    task automatic checkSequence(input string tag);
        logic [DW-1:0] expData [5];
        logic          expLast [5];
        expData = '{8'h05, 8'hFA, 8'h03, 8'h07, 8'hF7};
        expLast = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check({tag, "_beat_count"}, 32'(beats.size()), 32'(5));
        check({tag, "_done_count"}, 32'(doneCount), 32'(1));
        for (int i = 0; i < 5; i++) begin
            if (i < beats.size()) begin
                check($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(expData[i]));
                check($sformatf("%s_last%0d", tag, i), 32'(lasts[i]), 32'(expLast[i]));
            end
        end
    endtask

    initial begin
        memB[0]  = 8'h05;
        memB[1]  = 8'hFA;
        memB[2]  = 8'h03;
        memB[3]  = 8'h07;
        memB1[0] = 8'h00;
        memB1[1] = 8'h55;
        memB1[2] = 8'hAA;
        memB1[3] = 8'h11;

        // 1. Reset for 3 cycles, then idle with Ready=1 and no Start.
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("reset_outputs", {Valid, Last, Busy, Done, RdAddr, DataOut}, 32'(0));
            check("reset_outputs_1w", {valid1, last1, busy1, done1, rdAddr1, dataOut1}, 32'(0));
        end
        Reset = 1'b1;
        Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("idle_outputs", {Valid, Last, Busy, Done, RdAddr, DataOut}, 32'(0));
        end

        // 2. Full-throughput run: first Valid 2 cycles and Done 10 cycles after Start.
        pulseStart();
        drain(0, 1'b0);
        checkSequence("fast");
        check("fast_first_valid_cycle", 32'(firstValidCycle), 32'(1));
        check("fast_done_cycle", 32'(doneCycle), 32'(9));
        check("fast_busy_after_done", 32'(busyAfterDone), 32'(0));

        // 3. Three stall cycles on every beat.
        pulseStart();
        drain(3, 1'b0);
        checkSequence("stall");

        // 4. Start re-pulsed mid-run is ignored.
        pulseStart();
        drain(0, 1'b1);
        checkSequence("restart");

        // 5. Reset during the beat-1 stall aborts the run.
        pulseStart();
        @(negedge Clk);                     // LOAD word 0
        Start = 1'b0;
        @(negedge Clk);                     // SEND word 0, accepted
        check("abort_beat0", 32'(DataOut), 32'(8'h05));
        @(negedge Clk);                     // LOAD word 1
        Ready = 1'b0;
        @(negedge Clk);                     // SEND word 1, stalled
        check("abort_stall_valid", 32'(Valid), 32'(1));
        check("abort_stall_data", 32'(DataOut), 32'(8'hFA));
        check("abort_stall_addr", 32'(RdAddr), 32'(1));
        #2 Reset = 1'b0;
        #1 check("abort_immediate", {Valid, Last, Busy, Done, RdAddr, DataOut}, 32'(0));
        @(negedge Clk);
        Reset = 1'b1;
        Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("abort_no_resume", {Valid, Busy, Done}, 32'(0));
        end
        pulseStart();
        drain(0, 1'b0);
        checkSequence("after_abort");

        // 6. Single-word instance, B[0] = 00: beats 00, then checksum 00 with Last.
        @(negedge Clk);
        ready1 = 1'b1;
        start1 = 1'b1;
        @(negedge Clk);                     // LOAD
        start1 = 1'b0;
        check("one_load", {valid1, busy1, done1}, 32'(3'b010));
        @(negedge Clk);                     // SEND
        check("one_beat_valid", {valid1, last1}, 32'(2'b10));
        check("one_beat_data", 32'(dataOut1), 32'(8'h00));
        check("one_beat_addr", 32'(rdAddr1), 32'(0));
        @(negedge Clk);                     // CSUM
        check("one_csum_valid", {valid1, last1}, 32'(2'b11));
        check("one_csum_data", 32'(dataOut1), 32'(8'h00));
        check("one_csum_addr", 32'(rdAddr1), 32'(0));
        @(negedge Clk);                     // DONE
        check("one_done", {valid1, busy1, done1}, 32'(3'b011));
        @(negedge Clk);                     // IDLE
        check("one_idle", {valid1, busy1, done1}, 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
